// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris score path: FSM states, the
// line-clear points table, score limits and the double-dabble digit adjust.
package tetris_pkg;

    localparam int SCORE_W  = 14;
    localparam int BCD_W    = 16;
    localparam int LINES_W  = 3;
    localparam int SUM_W    = 15;
    localparam int DD_ITERS = 14;

    localparam logic [SCORE_W-1:0] MAX_SCORE = 14'd9999;

    // Indexed directly by the registered line count; illegal counts map to 0.
    localparam logic [SUM_W-1:0] POINTS [8] = '{
        15'd0, 15'd10, 15'd30, 15'd50, 15'd80, 15'd0, 15'd0, 15'd0
    };

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        CONV,
        PUBLISH
    } state_t;

    function automatic logic [BCD_W-1:0] bcdAdjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] adjusted;
        adjusted = bcd;
        for (int d = 0; d < 4; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                adjusted[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
        return adjusted;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one add-3/shift step per clock.
// o_done is high during the final step, so o_bcd is valid from the next cycle.
module bin2bcd_seq
    import tetris_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [SCORE_W-1:0] i_bin,
    output logic               o_done,
    output logic [BCD_W-1:0]   o_bcd
);

    logic [BCD_W+SCORE_W-1:0] r_shift;
    logic [3:0]               r_cnt;
    logic                     r_active;
    logic [BCD_W-1:0]         w_adjusted;

    assign w_adjusted = bcdAdjust(r_shift[BCD_W+SCORE_W-1:SCORE_W]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_shift  <= {{BCD_W{1'b0}}, i_bin};
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_shift <= {w_adjusted, r_shift[SCORE_W-1:0]} << 1;
            r_cnt   <= r_cnt + 4'd1;
            if (r_cnt == 4'(DD_ITERS - 1)) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_done = r_active && (r_cnt == 4'(DD_ITERS - 1));
    assign o_bcd  = r_shift[BCD_W+SCORE_W-1:SCORE_W];

endmodule

// File: rtl/score_ctrl.sv
// Score controller: accepts line-clear events, adds saturating points, converts
// the score to BCD for the display and runs the free-running digit-scan divider.
module score_ctrl
    import tetris_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_valid,
    input  logic [LINES_W-1:0] clr_lines,
    output logic               clr_ready,
    input  logic               game_reset,
    output logic [SCORE_W-1:0] score_bin,
    output logic [BCD_W-1:0]   score_bcd,
    output logic               bcd_valid,
    output logic               scan_tick,
    output logic               busy
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    state_t               r_state;
    state_t               w_nextState;
    logic [LINES_W-1:0]   r_lines;
    logic [SCORE_W-1:0]   r_scoreBin;
    logic [BCD_W-1:0]     r_scoreBcd;
    logic                 r_bcdValid;
    logic [DIV_W-1:0]     r_divCnt;
    logic                 r_scanTick;

    logic                 w_accept;
    logic                 w_legal;
    logic                 w_load;
    logic [SUM_W-1:0]     w_sum;
    logic [SCORE_W-1:0]   w_satSum;
    logic                 w_engDone;
    logic [BCD_W-1:0]     w_engBcd;

    assign clr_ready = (r_state == IDLE) && !game_reset;
    assign busy      = (r_state != IDLE);
    assign w_accept  = clr_valid && clr_ready;
    assign w_legal   = (r_lines != 3'd0) && (r_lines <= 3'd4);
    assign w_sum     = {1'b0, r_scoreBin} + POINTS[r_lines];
    assign w_satSum  = (w_sum > {1'b0, MAX_SCORE}) ? MAX_SCORE : w_sum[SCORE_W-1:0];

    bin2bcd_seq u_bin2bcd (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_bin  (w_satSum),
        .o_done (w_engDone),
        .o_bcd  (w_engBcd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // game_reset overrides every state, which also aborts any conversion in flight.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        if (game_reset) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clr_valid) begin
                        w_nextState = ADD;
                    end
                end
                ADD: begin
                    if (w_legal) begin
                        w_load      = 1'b1;
                        w_nextState = CONV;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
                CONV: begin
                    if (w_engDone) begin
                        w_nextState = PUBLISH;
                    end
                end
                PUBLISH: begin
                    w_nextState = IDLE;
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lines    <= '0;
            r_scoreBin <= '0;
            r_scoreBcd <= '0;
            r_bcdValid <= 1'b0;
        end else if (game_reset) begin
            r_scoreBin <= '0;
            r_scoreBcd <= '0;
            r_bcdValid <= 1'b1;
        end else begin
            r_bcdValid <= (r_state == PUBLISH);
            if (w_accept) begin
                r_lines <= clr_lines;
            end
            if ((r_state == ADD) && w_legal) begin
                r_scoreBin <= w_satSum;
            end
            if (r_state == PUBLISH) begin
                r_scoreBcd <= w_engBcd;
            end
        end
    end

    // Display scan divider runs regardless of game state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_divCnt   <= '0;
            r_scanTick <= 1'b0;
        end else begin
            r_scanTick <= (r_divCnt == DIV_LAST);
            r_divCnt   <= (r_divCnt == DIV_LAST) ? '0 : r_divCnt + 1'b1;
        end
    end

    assign score_bin = r_scoreBin;
    assign score_bcd = r_scoreBcd;
    assign bcd_valid = r_bcdValid;
    assign scan_tick = r_scanTick;

endmodule
